// File: rtl/rate_tick_sequencer_if.sv
//------------------------------------------------------------------------------
// rate_tick_sequencer_if : controller/ROM/timebase signal bundle for the
//                          rate tick sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rate_tick_sequencer_if #(
  parameter int SEL_W = 4,
  parameter int CNT_W = 32
);
  logic             en;
  logic             rate_req;
  logic [SEL_W-1:0] rate_sel;
  logic             rate_ack;
  logic [SEL_W-1:0] rom_sel;
  logic [CNT_W-1:0] rom_data;
  logic [SEL_W-1:0] cur_sel;
  logic             tick;
  logic             busy;

  // System side: controller request, run enable and the ROM read data.
  modport master (
    output en, rate_req, rate_sel, rom_data,
    input  rate_ack, rom_sel, cur_sel, tick, busy
  );

  modport slave (
    input  en, rate_req, rate_sel, rom_data,
    output rate_ack, rom_sel, cur_sel, tick, busy
  );
endinterface

`default_nettype wire

// File: rtl/rate_tick_sequencer.sv
//------------------------------------------------------------------------------
// rate_tick_sequencer : ROM-driven down-counter emitting a tick every ldv+1
//                       clocks, with rate changes applied on period boundaries
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rate_tick_sequencer #(
  parameter int SEL_W     = 4,
  parameter int CNT_W     = 32,
  parameter int MIN_COUNT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rate_tick_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] C_MIN_COUNT = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] ldv;

  assign ldv = (bus.rom_data < C_MIN_COUNT) ? C_MIN_COUNT : bus.rom_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      cur_sel_q  <= '0;
      pend_sel_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;

    // Blocking capture during the ack cycle keeps a still-high req from re-arming.
    if (bus.rate_req && !pend_q && !ack_q) begin
      pend_d     = 1'b1;
      pend_sel_d = bus.rate_sel;
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          cur_sel_d = pend_sel_q;
          pend_d    = 1'b0;
          ack_d     = 1'b1;
        end else if (bus.en) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (!bus.en) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = ldv;
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (!bus.en) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q != '0) begin
          count_d = count_q - C_ONE;
        end else begin
          tick_d = 1'b1;
          // A change costs one LOAD cycle so the ROM sees the new select first.
          if (pend_q) begin
            cur_sel_d = pend_sel_q;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
            state_d   = LOAD;
          end else begin
            count_d = ldv;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign bus.rate_ack = ack_q;
  assign bus.rom_sel  = cur_sel_q;
  assign bus.cur_sel  = cur_sel_q;
  assign bus.tick     = tick_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/rate_tick_sequencer.md
Name: rate_tick_sequencer

Overview:
- Drives the select input of the divider-constant ROM, loads the returned 32-bit terminal count into a down-counter, and emits a one-cycle `tick` every (count+1) clocks.
- Accepts rate-change requests from the pico controller over a req/ack handshake. A change is applied only at a period boundary, so no truncated or glitched period is ever produced.
- Sits between the controller and the ROM. `tick` feeds the blink/scan/timebase logic.

Parameters:
- SEL_W, 4, width of the ROM select and of `rate_sel`.
- CNT_W, 32, width of the ROM data and of the down-counter.
- MIN_COUNT, 1, floor applied to the loaded count. A ROM value below MIN_COUNT is loaded as MIN_COUNT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable. Level-sensitive.
- rate_req  in  1  rate-change request. Level; held until `rate_ack`.
- rate_sel  in  SEL_W  requested ROM index. Stable while `rate_req`=1.
- rate_ack  out  1  one-cycle pulse: request accepted and applied.
- rom_sel  out  SEL_W  select to the ROM. Always equals `cur_sel`.
- rom_data  in  CNT_W  ROM output. Combinational, valid in the same cycle as `rom_sel`.
- cur_sel  out  SEL_W  currently active rate index.
- tick  out  1  one-cycle timebase pulse. Registered.
- busy  out  1  1 when state ≠ IDLE.

Behaviour:
- Reset (rst=1 at a clk edge, which overrides everything):
  - state=IDLE; cur_sel=0; count=0; pend=0; pend_sel=0.
  - tick=0, rate_ack=0, busy=0.
  - Reset mid-count aborts the period with no tick, and discards any pending request without an ack.
- Load value: `ldv = (rom_data < MIN_COUNT) ? MIN_COUNT : rom_data`, unsigned CNT_W compare.
- Request capture:
  - Capture when `rate_req`=1 and pend=0 and rate_ack=0: pend_sel<=rate_sel, pend<=1.
  - While pend=1 or in the ack cycle, `rate_req` is ignored, so a req still high in the ack cycle is not re-captured.
  - The requester must drop `rate_req` on the cycle after `rate_ack`.
- FSM states: IDLE, LOAD, COUNT.
  - IDLE:
    - If pend=1: cur_sel<=pend_sel, pend<=0, rate_ack=1 next cycle. Applies even with en=0.
    - Else if en=1: go to LOAD.
    - A request captured in IDLE is applied in the following cycle.
  - LOAD:
    - count<=ldv for `cur_sel`; go to COUNT.
    - If en=0: go to IDLE, count<=0.
  - COUNT, when en=0: go to IDLE, count<=0, no tick. The pending request is kept and is applied in IDLE.
  - COUNT, when count≠0: count<=count-1.
  - COUNT, when count==0: tick=1 on the next cycle, then:
    - If pend=1: cur_sel<=pend_sel, pend<=0, rate_ack=1 in the same cycle as tick; go to LOAD.
    - Else: count<=ldv and stay in COUNT, giving a seamless reload.
- Timing:
  - Steady-state tick spacing is exactly ldv+1 clocks.
  - The first tick after IDLE→LOAD arrives ldv+2 clocks after leaving IDLE.
  - The first period after a rate change is new ldv+2 clocks; the extra cycle is the LOAD state.
- A request that arrives in the same cycle as count==0 with pend=0 is captured but not applied at that boundary. It is applied at the next boundary.
- `rom_sel` is driven from the `cur_sel` register only and never from `pend_sel`.
- The counter never wraps: decrement happens only when count≠0.

Test Plan:
- Reset, then en=1 with cur_sel=0 and the ROM stubbed to 4 at every index -> first tick 6 clocks after leaving IDLE, then every 5 clocks. busy=1, rate_ack stays 0.
- Real ROM, rate_req with rate_sel=3 while idle (en=0) -> rate_ack one cycle later, cur_sel=3. Then en=1 -> tick spacing 2500 clocks.
- Stubbed ROM (sel0=9, sel1=2); running at sel0, req sel1 mid-period -> current 10-clock period completes. tick and rate_ack coincide; next tick 4 clocks later, then every 3.
- ROM returns 0 with MIN_COUNT=1 -> tick every 2 clocks, never every cycle. rate_req held high through the ack -> exactly one rate_ack.
- rst=1 mid-COUNT with a pending request -> next cycle tick=0, busy=0, cur_sel=0, no rate_ack. Also en drop mid-period -> IDLE, no tick.
- Request in the same cycle as terminal count -> not acked at that tick. Applied with rate_ack at the following boundary.
